// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared FSM state type and window/pipeline constants for sobel_ctrl
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    LINE   = 2'd2,
    HBLANK = 2'd3
  } sobel_st_t;

  localparam int WIN_SIZE     = 3;
  localparam int DEF_PIPE_LAT = 4;

endpackage

// File: rtl/sobel_ctrl_sync_delay.sv
// rtl/sobel_ctrl_sync_delay.sv - DEPTH-stage delay line for the {dv, hs, vs} timing triple
module sync_delay #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  logic [2:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sobel_ctrl.sv
// rtl/sobel_ctrl.sv - Sobel front-end timing controller: frame/line FSM, coordinates, window flags.
// Border flag is built only when SOBEL_CTRL_BORDER_EN is defined; otherwise border_o is 0.
module sobel_ctrl
  import sobel_pkg::*;
#(
  parameter int MAX_W    = 2048,
  parameter int MAX_H    = 2048,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dv_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic                   line_end_o,
  output logic [$clog2(MAX_W):0] col_o,
  output logic [$clog2(MAX_H):0] row_o,
  output logic                   win_valid_o,
  output logic                   border_o,
  output logic                   frame_start_o,
  output logic [$clog2(MAX_W):0] width_o,
  output logic                   dv_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   len_err_o
);

  localparam int CW = $clog2(MAX_W) + 1;
  localparam int RW = $clog2(MAX_H) + 1;
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(MAX_H - 1);

  sobel_st_t     state, state_nxt;
  logic          vs_q, vs_rise;
  logic          pix, pix_q;
  logic          start_frame, start_line, end_line, to_vblank;
  logic [CW-1:0] col, width, line_cnt;
  logic [RW-1:0] row;
  logic          len_err;
  logic [2:0]    sync_q;

  assign vs_rise  = vs_i & ~vs_q;
  assign line_cnt = col + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      vs_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_q  <= vs_i;
    end
  end

  // vs rising in VBLANK is ignored so a frame can start on the same cycle as a late vs edge
  always_comb begin
    state_nxt   = state;
    pix         = 1'b0;
    start_frame = 1'b0;
    start_line  = 1'b0;
    end_line    = 1'b0;
    to_vblank   = 1'b0;
    case (state)
      IDLE:   if (vs_rise) state_nxt = VBLANK;
      VBLANK: if (dv_i) begin
        state_nxt   = LINE;
        pix         = 1'b1;
        start_frame = 1'b1;
      end
      LINE: begin
        if (vs_rise) begin
          state_nxt = VBLANK;
          to_vblank = 1'b1;
        end else if (dv_i) begin
          pix = 1'b1;
        end else begin
          state_nxt = HBLANK;
          end_line  = 1'b1;
        end
      end
      HBLANK: begin
        if (vs_rise) begin
          state_nxt = VBLANK;
          to_vblank = 1'b1;
        end else if (dv_i) begin
          state_nxt  = LINE;
          pix        = 1'b1;
          start_line = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      width         <= '0;
      len_err       <= 1'b0;
      pix_q         <= 1'b0;
      line_end_o    <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      pix_q         <= pix;
      line_end_o    <= end_line;
      frame_start_o <= start_frame;
      if (to_vblank) begin
        col <= '0;
        row <= '0;
      end else if (start_frame) begin
        col     <= '0;
        row     <= '0;
        len_err <= 1'b0;
      end else if (start_line) begin
        col <= '0;
        if (row == ROW_MAX) len_err <= 1'b1;
        else                row     <= row + RW'(1);
      end else if (pix) begin
        if (col == COL_MAX) len_err <= 1'b1;
        else                col     <= col + CW'(1);
      end
      // the first line of each frame defines the reference width for the rest
      if (end_line) begin
        if (row == '0)                width   <= line_cnt;
        else if (line_cnt != width)   len_err <= 1'b1;
      end
    end
  end

  assign col_o       = col;
  assign row_o       = row;
  assign width_o     = width;
  assign len_err_o   = len_err;
  assign win_valid_o = pix_q && (col >= CW'(WIN_SIZE - 1)) && (row >= RW'(WIN_SIZE - 1));

`ifdef SOBEL_CTRL_BORDER_EN
  assign border_o = pix_q && ((col == '0) || (row == '0) ||
                              ((row != '0) && (col == width - CW'(1))));
`else
  assign border_o = 1'b0;
`endif

  sync_delay #(
    .DEPTH(PIPE_LAT)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .din ({dv_i, hs_i, vs_i}),
    .dout(sync_q)
  );

  assign dv_o = sync_q[2];
  assign hs_o = sync_q[1];
  assign vs_o = sync_q[0];

endmodule

// File: tb/tb_sobel_ctrl.sv
// tb/tb_sobel_ctrl.sv - self-checking bench for sobel_ctrl against a frame-level reference model
module tb_sobel_ctrl;

  localparam int MAX_W    = 16;
  localparam int MAX_H    = 8;
  localparam int PIPE_LAT = 4;
  localparam int CW       = $clog2(MAX_W) + 1;
  localparam int RW       = $clog2(MAX_H) + 1;
`ifdef SOBEL_CTRL_BORDER_EN
  localparam bit BD_EN = 1'b1;
`else
  localparam bit BD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic          line_end_o, win_valid_o, border_o, frame_start_o;
  logic          dv_o, hs_o, vs_o, len_err_o;
  logic [CW-1:0] col_o, width_o;
  logic [RW-1:0] row_o;
  logic [8+2*CW+RW-1:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;
  int width_m = 0;
  int err_m   = 0;

  typedef struct {
    logic d, h, v, le, fs, win, bd, err, chk;
    int   col, row, width;
  } cyc_t;

  always #5 clk = ~clk;

  sobel_ctrl #(.MAX_W(MAX_W), .MAX_H(MAX_H), .PIPE_LAT(PIPE_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .dv_i         (dv_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .line_end_o   (line_end_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .win_valid_o  (win_valid_o),
    .border_o     (border_o),
    .frame_start_o(frame_start_o),
    .width_o      (width_o),
    .dv_o         (dv_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .len_err_o    (len_err_o)
  );

  assign all_out = {line_end_o, win_valid_o, border_o, frame_start_o, dv_o, hs_o, vs_o,
                    len_err_o, col_o, row_o, width_o};

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic cyc_t blank(input logic v);
    cyc_t c;
    c.d = 1'b0; c.h = 1'b0; c.v = v; c.le = 1'b0; c.fs = 1'b0; c.win = 1'b0;
    c.bd = 1'b0; c.err = (err_m != 0); c.chk = 1'b0;
    c.col = 0; c.row = 0; c.width = width_m;
    return c;
  endfunction

  task automatic tick(input logic d, input logic h, input logic v);
    dv_i = d; hs_i = h; vs_i = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    width_m = 0;
    err_m   = 0;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h expected 0", all_out);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%h expected 0", all_out);
    end
  endtask

  task automatic test_idle_ignore();
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({frame_start_o, line_end_o, win_valid_o, border_o, len_err_o, col_o, row_o} !== '0) begin
        n_fail++;
        $display("FAIL idle_ignore[%0d]: fs=%b le=%b win=%b col=%0d row=%0d expected all 0",
                 k, frame_start_o, line_end_o, win_valid_o, col_o, row_o);
      end
    end
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sync_delay();
    logic [2:0] hist[$];
    logic [2:0] exp_s;
    logic       d, h, v;
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      d = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      h = (k == 10);
      hist.push_back({d, h, v});
      tick(d, h, v);
      exp_s = (k >= PIPE_LAT - 1) ? hist[k-PIPE_LAT+1] : 3'b000;
      n_tests++;
      if ({dv_o, hs_o, vs_o} !== exp_s) begin
        n_fail++;
        $display("FAIL sync_delay[%0d]: dv/hs/vs_o=%b expected %b", k, {dv_o, hs_o, vs_o}, exp_s);
      end
    end
  endtask

  task automatic test_frames();
    cyc_t c;
    cyc_t q[$];
    int   len[$];
    int   nl, hb, ab_line, ab_col, w0, ie, je, cnt;
    int   le_cnt, win_cnt, le_exp, win_exp;
    bit   aborted;
    apply_reset();
    for (int s = 0; s < 14; s++) begin
      q.delete(); len.delete();
      ab_line = -1; ab_col = -1; hb = 4; nl = 4;
      case (s)
        0, 2, 4: for (int i = 0; i < 4; i++) len.push_back(8);
        1: begin len.push_back(8); len.push_back(7); len.push_back(8); len.push_back(8); end
        3: begin
          for (int i = 0; i < 4; i++) len.push_back(8);
          ab_line = 2; ab_col = 3;
        end
        5: begin nl = 2; hb = 3; len.push_back(20); len.push_back(20); end
        6: begin nl = 10; hb = 2; for (int i = 0; i < 10; i++) len.push_back(3); end
        7: begin hb = 1; for (int i = 0; i < 4; i++) len.push_back(5); end
        default: begin
          nl = $urandom_range(1, 5);
          hb = $urandom_range(1, 4);
          w0 = $urandom_range(1, 12);
          for (int i = 0; i < nl; i++)
            len.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : w0);
          if ($urandom_range(0, 3) == 0) begin
            ab_line = $urandom_range(0, nl - 1);
            if (len[ab_line] > 1) ab_col = $urandom_range(1, len[ab_line] - 1);
            else ab_line = -1;
          end
        end
      endcase

      for (int k = 0; k < 4; k++) q.push_back(blank(k < 2));
      aborted = 1'b0;
      for (int i = 0; i < nl && !aborted; i++) begin
        for (int j = 0; j < len[i]; j++) begin
          if (i == ab_line && j == ab_col) begin
            c = blank(1'b1); c.d = 1'b1; c.chk = 1'b1;
            q.push_back(c);
            aborted = 1'b1;
            break;
          end
          ie = imin(i, MAX_H - 1);
          je = imin(j, MAX_W - 1);
          if (i == 0 && j == 0) err_m = 0;
          if (j >= MAX_W || (j == 0 && i >= MAX_H)) err_m = 1;
          c = blank(1'b0);
          c.d = 1'b1; c.chk = 1'b1; c.col = je; c.row = ie;
          c.fs  = (i == 0 && j == 0);
          c.win = (ie >= 2 && je >= 2);
          c.bd  = BD_EN && (je == 0 || ie == 0 || je == width_m - 1);
          q.push_back(c);
        end
        if (!aborted) begin
          cnt = imin(len[i], MAX_W);
          if (i == 0) width_m = cnt;
          else if (cnt != width_m) err_m = 1;
          for (int k = 0; k < hb; k++) begin
            c = blank(1'b0);
            if (k == 0) begin c.le = 1'b1; c.h = 1'b1; end
            q.push_back(c);
          end
        end
      end

      le_cnt = 0; win_cnt = 0; le_exp = 0; win_exp = 0;
      foreach (q[k]) begin
        tick(q[k].d, q[k].h, q[k].v);
        le_cnt  += int'(line_end_o);
        win_cnt += int'(win_valid_o);
        le_exp  += int'(q[k].le);
        win_exp += int'(q[k].win);
        n_tests++;
        if ({line_end_o, frame_start_o, win_valid_o, border_o, len_err_o} !==
            {q[k].le, q[k].fs, q[k].win, q[k].bd, q[k].err}) begin
          n_fail++;
          $display("FAIL frame%0d_flags[%0d]: le/fs/win/bd/err=%b expected %b", s, k,
                   {line_end_o, frame_start_o, win_valid_o, border_o, len_err_o},
                   {q[k].le, q[k].fs, q[k].win, q[k].bd, q[k].err});
        end
        n_tests++;
        if (width_o !== CW'(q[k].width)) begin
          n_fail++;
          $display("FAIL frame%0d_width[%0d]: width_o=%0d expected %0d", s, k, width_o, q[k].width);
        end
        if (q[k].chk) begin
          n_tests++;
          if (col_o !== CW'(q[k].col) || row_o !== RW'(q[k].row)) begin
            n_fail++;
            $display("FAIL frame%0d_coord[%0d]: col=%0d row=%0d expected col=%0d row=%0d",
                     s, k, col_o, row_o, q[k].col, q[k].row);
          end
        end
      end
      n_tests++;
      if (le_cnt != le_exp || win_cnt != win_exp) begin
        n_fail++;
        $display("FAIL frame%0d_counts: line_end=%0d win_valid=%0d expected %0d and %0d",
                 s, le_cnt, win_cnt, le_exp, win_exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) tick(1'b1, (j == 4), (j == 5));
    rst = 1'b1;
    #1;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h expected 0", all_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    width_m = 0; err_m = 0;
    for (int k = 1; k <= PIPE_LAT + 3; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({dv_o, hs_o, vs_o} !== {(k >= PIPE_LAT), 2'b00}) begin
        n_fail++;
        $display("FAIL post_reset_sync[%0d]: dv/hs/vs_o=%b expected %b", k,
                 {dv_o, hs_o, vs_o}, {(k >= PIPE_LAT), 2'b00});
      end
      n_tests++;
      if ({frame_start_o, line_end_o, len_err_o, col_o, row_o, width_o} !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle[%0d]: fs=%b le=%b err=%b col=%0d row=%0d width=%0d expected 0",
                 k, frame_start_o, line_end_o, len_err_o, col_o, row_o, width_o);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_ignore();
    test_sync_delay();
    test_frames();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete within time budget");
    $fatal(1);
  end

endmodule
